// File: rtl/imm_extend_pipe_pkg.sv
// imm_ext_pkg -- shared types and constants for the immediate extender.
//   ext_mode_e : extension mode carried alongside each immediate.
//   XFER_CNT_W : width of the delivered-result counter.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_SEXT     = 2'd0,
    EXT_ZEXT     = 2'd1,
    EXT_SEXT_SHL = 2'd2,
    EXT_HIGH     = 2'd3
  } ext_mode_e;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/imm_extend_pipe_reg.sv
// ext_pipe_reg -- one elastic valid/ready register slice.
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and registered payload
// in_ready is combinational from out_ready so a full slice can accept while
// it drains, giving full throughput without a skid buffer.
module ext_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Stalled: hold everything. Otherwise take the upstream item (or go empty).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe -- two-stage elastic immediate extender.
//   clk, rst                   : clock, async active-high reset
//   in_valid/in_ready          : decode-side handshake
//   ext_in, ext_mode, ext_shamt: immediate, mode (imm_ext_pkg::ext_mode_e), shift
//   out_valid/out_ready        : execute-side handshake
//   extend_out, ext_ovf        : registered result and shift-overflow flag
//   xfer_count                 : wrapping count of delivered results
// Stage 1 captures the raw fields; the extend logic sits between stage 1 and
// stage 2, so both outputs come straight from stage-2 flops.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int SHIFT_MAX = 3,
  parameter int SH_W      = $clog2(SHIFT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       ext_in,
  input  logic [1:0]            ext_mode,
  input  logic [SH_W-1:0]       ext_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      extend_out,
  output logic                  ext_ovf,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  localparam int              S1_W   = SH_W + 2 + IN_W;
  localparam int              S2_W   = OUT_W + 1;
  localparam int              WIDE_W = OUT_W + SHIFT_MAX;
  localparam logic [SH_W-1:0] SHM    = SH_W'(SHIFT_MAX);

  logic              s1_valid, s1_ready;
  logic [S1_W-1:0]   s1_data;
  logic [IN_W-1:0]   s1_imm;
  logic [1:0]        s1_mode;
  logic [SH_W-1:0]   s1_shamt;
  logic [S2_W-1:0]   s2_data;

  ext_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ext_shamt, ext_mode, ext_in}),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_data)
  );

  assign {s1_shamt, s1_mode, s1_imm} = s1_data;

  // ---- extend / shift / overflow ----
  logic signed [IN_W-1:0]  imm_s;
  logic signed [OUT_W-1:0] sx, shl_res;
  logic [OUT_W-1:0]        zx, res_c;
  logic [SH_W-1:0]         sh;
  logic                    clamp, ovf_c;

  always_comb begin
    imm_s   = s1_imm;
    sx      = OUT_W'(imm_s);
    zx      = OUT_W'(s1_imm);
    clamp   = s1_shamt > SHM;
    sh      = clamp ? SHM : s1_shamt;
    // Shift in the widened domain, then keep the low OUT_W bits.
    shl_res = OUT_W'(WIDE_W'(sx) << sh);
    res_c   = sx;
    ovf_c   = 1'b0;
    case (ext_mode_e'(s1_mode))
      EXT_SEXT: res_c = sx;
      EXT_ZEXT: res_c = zx;
      EXT_SEXT_SHL: begin
        res_c = shl_res;
        // Shifting back must reproduce the input, else significant bits fell off.
        ovf_c = clamp || ((shl_res >>> sh) != sx);
      end
      EXT_HIGH: res_c = zx << (OUT_W - IN_W);
      default: ;
    endcase
  end

  ext_pipe_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   ({ovf_c, res_c}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {ext_ovf, extend_out} = s2_data;

  // ---- delivered-result counter ----
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + XFER_CNT_W'(out_valid && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: default build driven through a scoreboard, plus
// an IN_W=8/OUT_W=8/SHIFT_MAX=2 build exercised directly.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  localparam int STREAM_N = 70000;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, ext_ovf;
  logic [7:0]  ext_in;
  logic [1:0]  ext_mode, ext_shamt;
  logic [15:0] extend_out, xfer_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ext_ovf;
  logic [7:0]  b_ext_in, b_extend_out;
  logic [1:0]  b_ext_mode, b_ext_shamt;
  logic [15:0] b_xfer_count;

  imm_extend_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ext_in(ext_in), .ext_mode(ext_mode), .ext_shamt(ext_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .extend_out(extend_out),
    .ext_ovf(ext_ovf), .xfer_count(xfer_count)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(8), .SHIFT_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ext_in(b_ext_in), .ext_mode(b_ext_mode), .ext_shamt(b_ext_shamt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .extend_out(b_extend_out),
    .ext_ovf(b_ext_ovf), .xfer_count(b_xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [1:0]  sh;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, n_out = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference for the default build (8 -> 16, SHIFT_MAX 3).
  function automatic void model(input logic [7:0] imm, input logic [1:0] md,
                                input logic [1:0] sh, output logic [15:0] r,
                                output logic o);
    int sx, v, shc;
    sx  = imm[7] ? int'(imm) - 256 : int'(imm);
    shc = (int'(sh) > 3) ? 3 : int'(sh);
    o   = 1'b0;
    case (md)
      2'd0: r = 16'(sx);
      2'd1: r = {8'h00, imm};
      2'd2: begin
        v = sx * (1 << shc);
        r = 16'(v);
        o = (int'(sh) > 3) || (v > 32767) || (v < -32768);
      end
      default: r = {imm, 8'h00};
    endcase
  endfunction

  // Scoreboard: every delivered output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got %0h with nothing expected", extend_out);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_data", 32'(extend_out), 32'(mon_e.d));
        check("sb_ovf", 32'(ext_ovf), 32'(mon_e.o));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 15) != 0);
    end
  end

  // All tasks start and end at posedge+1.
  task automatic offer(input logic [7:0] imm, input logic [1:0] md, input logic [1:0] sh,
                       input logic [15:0] ed, input logic eo, input int budget);
    in_valid = 1'b1; ext_in = imm; ext_mode = md; ext_shamt = sh;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({ed, eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("offer_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check({nm, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic b_run(input string nm, input vec_t v);
    bit got = 1'b0;
    b_in_valid = 1'b1; b_ext_in = v.imm; b_ext_mode = v.mode; b_ext_shamt = v.sh;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        got = 1'b1;
        check({nm, "_data"}, 32'(b_extend_out), 32'(v.exp_d[7:0]));
        check({nm, "_ovf"}, 32'(b_ext_ovf), 32'(v.exp_o));
      end
    end
    if (!got) check({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[11];
  vec_t lat[3];
  vec_t bvecs[9];
  logic [15:0] md_d;
  logic        md_o;
  logic [7:0]  r_imm;
  logic [1:0]  r_md, r_sh;
  int          k, n0;

  initial begin
    vecs[0]  = '{8'h80, EXT_SEXT,     2'd0, 16'hFF80, 1'b0};
    vecs[1]  = '{8'h80, EXT_ZEXT,     2'd0, 16'h0080, 1'b0};
    vecs[2]  = '{8'h7F, EXT_SEXT,     2'd0, 16'h007F, 1'b0};
    vecs[3]  = '{8'h12, EXT_HIGH,     2'd0, 16'h1200, 1'b0};
    vecs[4]  = '{8'hC0, EXT_SEXT_SHL, 2'd2, 16'hFF00, 1'b0};
    vecs[5]  = '{8'h40, EXT_SEXT_SHL, 2'd3, 16'h0200, 1'b0};
    vecs[6]  = '{8'h80, EXT_SEXT_SHL, 2'd3, 16'hFC00, 1'b0};
    vecs[7]  = '{8'h7F, EXT_SEXT_SHL, 2'd0, 16'h007F, 1'b0};
    vecs[8]  = '{8'h80, EXT_SEXT,     2'd3, 16'hFF80, 1'b0};
    vecs[9]  = '{8'hFF, EXT_HIGH,     2'd1, 16'hFF00, 1'b0};
    vecs[10] = '{8'h01, EXT_SEXT_SHL, 2'd1, 16'h0002, 1'b0};
    lat[0] = vecs[0];
    lat[1] = vecs[1];
    lat[2] = vecs[2];
    bvecs[0] = '{8'h40, EXT_SEXT_SHL, 2'd1, 16'h0080, 1'b1};
    bvecs[1] = '{8'h01, EXT_SEXT_SHL, 2'd3, 16'h0004, 1'b1};
    bvecs[2] = '{8'h20, EXT_SEXT_SHL, 2'd2, 16'h0080, 1'b1};
    bvecs[3] = '{8'h10, EXT_SEXT_SHL, 2'd2, 16'h0040, 1'b0};
    bvecs[4] = '{8'hE0, EXT_SEXT_SHL, 2'd2, 16'h0080, 1'b0};
    bvecs[5] = '{8'hFF, EXT_SEXT_SHL, 2'd3, 16'h00FC, 1'b1};
    bvecs[6] = '{8'h80, EXT_SEXT,     2'd0, 16'h0080, 1'b0};
    bvecs[7] = '{8'hA5, EXT_ZEXT,     2'd0, 16'h00A5, 1'b0};
    bvecs[8] = '{8'h12, EXT_HIGH,     2'd0, 16'h0012, 1'b0};

    rst = 1'b0; in_valid = 1'b0; ext_in = '0; ext_mode = '0; ext_shamt = '0;
    out_ready = 1'b0;
    b_in_valid = 1'b0; b_ext_in = '0; b_ext_mode = '0; b_ext_shamt = '0;
    b_out_ready = 1'b1;

    // ---- reset state ----
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_extend_out", 32'(extend_out), 32'h0);
    check("rst_ovf", 32'(ext_ovf), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ---- latency: result visible after the second edge ----
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; ext_in = lat[i].imm; ext_mode = lat[i].mode; ext_shamt = lat[i].sh;
      sbq.push_back({lat[i].exp_d, lat[i].exp_o});
      @(negedge clk);
      check("lat_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      check("lat_edge2_data", 32'(extend_out), 32'(lat[i].exp_d));
      @(posedge clk); #1;
    end
    drain("lat");

    // ---- table vectors, back to back ----
    for (int i = 0; i < 11; i++)
      offer(vecs[i].imm, vecs[i].mode, vecs[i].sh, vecs[i].exp_d, vecs[i].exp_o, 8);
    drain("table");

    // ---- narrow build: OUT_W == IN_W, SHIFT_MAX 2 ----
    for (int i = 0; i < 9; i++) b_run($sformatf("b_vec%0d", i), bvecs[i]);

    // ---- stall: hold out_ready low while offering three items ----
    pulse_reset();
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (k < 3); ext_in = 8'(k + 1); ext_mode = EXT_ZEXT; ext_shamt = 2'd0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        sbq.push_back({16'(k + 1), 1'b0});
        k++;
      end
      @(posedge clk); #1;
    end
    check("stall_accepted", 32'(k), 32'd2);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
      in_valid = 1'b1; ext_in = 8'(k + 1);
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({16'(k + 1), 1'b0});
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_all_accepted", 32'(k), 32'd3);
    drain("stall");
    check("stall_xfer_count", 32'(xfer_count), 32'd3);

    // ---- reset with two items held ----
    out_ready = 1'b0;
    offer(8'hAA, EXT_ZEXT, 2'd0, 16'h00AA, 1'b0, 8);
    offer(8'hBB, EXT_ZEXT, 2'd0, 16'h00BB, 1'b0, 8);
    check("mid_full_in_ready", 32'(in_ready), 32'd0);
    check("mid_full_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_extend_out", 32'(extend_out), 32'h0);
    check("mid_rst_xfer_count", 32'(xfer_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_stale", 32'(n_out - n0), 32'd0);
    check("mid_rst_idle_valid", 32'(out_valid), 32'd0);

    // ---- long random stream ----
    pulse_reset();
    n0 = n_out;
    rand_rdy = 1'b1;
    for (int s = 0; s < STREAM_N; s++) begin
      r_imm = 8'($urandom);
      r_md  = 2'($urandom_range(0, 3));
      r_sh  = 2'($urandom_range(0, 3));
      model(r_imm, r_md, r_sh, md_d, md_o);
      offer(r_imm, r_md, r_sh, md_d, md_o, 64);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain("stream");
    check("stream_xfer_count", 32'(xfer_count), 32'(STREAM_N % 65536));
    check("stream_outputs", 32'(n_out - n0), 32'(STREAM_N));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
